// File: rtl/decode_regfile_pipe_if.sv
// -----------------------------------------------------------------------------
// decode_regfile_pipe_if
//
// Bundles the decode-side signals of decode_regfile_pipe: the two read indices,
// the two writeback ports, the pipeline controls and the registered results
// handed to the execute stage.
//
//   master : drives read indices, writebacks, stall/bubble; receives results
//   slave  : the register file / pipeline register itself
//
// Signals
//   srcA, srcB        read port indices
//   in_valid          decode slot holds a real instruction
//   dstE, valE        writeback port E (from execute)
//   dstM, valM        writeback port M (from memory)
//   stall, bubble     pipeline register controls
//   valA, valB        registered read results
//   srcA_q, srcB_q    registered read indices
//   out_valid         registered in_valid (0 for a bubble)
// -----------------------------------------------------------------------------
interface decode_regfile_pipe_if #(
  parameter int DATA_W = 32
);

  logic [3:0]        srcA;
  logic [3:0]        srcB;
  logic              in_valid;
  logic [3:0]        dstE;
  logic [DATA_W-1:0] valE;
  logic [3:0]        dstM;
  logic [DATA_W-1:0] valM;
  logic              stall;
  logic              bubble;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic [3:0]        srcA_q;
  logic [3:0]        srcB_q;
  logic              out_valid;

  modport master (
    output srcA, srcB, in_valid,
    output dstE, valE, dstM, valM,
    output stall, bubble,
    input  valA, valB, srcA_q, srcB_q, out_valid
  );

  modport slave (
    input  srcA, srcB, in_valid,
    input  dstE, valE, dstM, valM,
    input  stall, bubble,
    output valA, valB, srcA_q, srcB_q, out_valid
  );

endinterface

// File: rtl/decode_regfile_pipe.sv
// -----------------------------------------------------------------------------
// decode_regfile_pipe
//
// Y86 decode-stage register file with an integrated decode/execute pipeline
// register.
//
//   - NUM_REGS architectural registers, two writeback ports per cycle (E and M).
//     When both ports target the same register, M wins (popq %rsp semantics).
//   - Two read ports, bypassed past the writes presented in the same cycle, so
//     an instruction can read a value that is being written back right now.
//   - Read results, indices and valid are captured into an output register with
//     priority reset > stall > bubble > load.
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   bus     decode_regfile_pipe_if.slave (see interface header for signals)
//
// Parameters
//   DATA_W    register / value width
//   NUM_REGS  implemented registers, indices 0..NUM_REGS-1 (at most 15)
//   RSP_IDX   stack pointer index
//   RSP_INIT  reset value of the stack pointer
//   RNONE     "no register" index
// -----------------------------------------------------------------------------
module decode_regfile_pipe #(
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 15,
  parameter int                RSP_IDX  = 4,
  parameter logic [DATA_W-1:0] RSP_INIT = '0,
  parameter logic [3:0]        RNONE    = 4'hF
) (
  input  logic                 clk,
  input  logic                 reset,
  decode_regfile_pipe_if.slave bus
);

  localparam logic [3:0] NUM_REGS_L = 4'(NUM_REGS);

  // Pipeline register action for this cycle, already priority-resolved.
  typedef enum logic [1:0] {
    PIPE_RESET,
    PIPE_HOLD,
    PIPE_BUBBLE,
    PIPE_LOAD
  } pipeCtl_e;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // An index names an implemented register. Used both for write legality and
  // for deciding whether a read returns a register or the constant 0.
  function automatic logic legalIdx(input logic [3:0] idx);
    return (idx != RNONE) && (idx < NUM_REGS_L);
  endfunction

  // Bypassed read: M is checked before E so a same-cycle dual write to one
  // register is seen exactly as the array will store it.
  function automatic logic [DATA_W-1:0] bypassRead(
    input logic [3:0]        src,
    input logic [DATA_W-1:0] arrVal,
    input logic              weE,
    input logic [3:0]        dstE,
    input logic [DATA_W-1:0] valE,
    input logic              weM,
    input logic [3:0]        dstM,
    input logic [DATA_W-1:0] valM
  );
    logic [DATA_W-1:0] res;
    if (!legalIdx(src))            res = '0;
    else if (weM && (src == dstM)) res = valM;
    else if (weE && (src == dstE)) res = valE;
    else                           res = arrVal;
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regFile [NUM_REGS];

  logic weE;
  logic weM;

  assign weE = legalIdx(bus.dstE);
  assign weM = legalIdx(bus.dstM);

  // Writeback is independent of stall/bubble/in_valid. The loop uses constant
  // indices so no 4-bit index ever addresses a smaller array.
  // NOTE: the array is reset on purpose -- these are architectural registers
  // with defined reset values (RSP_INIT for the stack pointer, 0 elsewhere).
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        // NOTE: non-blocking assignments for all state, so every flop samples
        // pre-edge values regardless of statement order.
        regFile[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
      end else if (weM && (bus.dstM == 4'(i))) begin
        regFile[i] <= bus.valM;
      end else if (weE && (bus.dstE == 4'(i))) begin
        regFile[i] <= bus.valE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] arrA;
  logic [DATA_W-1:0] arrB;
  logic [DATA_W-1:0] rdA;
  logic [DATA_W-1:0] rdB;

  // Array read mux; out-of-range indices fall through to 0 and are masked
  // again by bypassRead.
  always_comb begin
    // NOTE: defaults first so every path assigns -- no latches inferred.
    arrA = '0;
    arrB = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.srcA == 4'(i)) arrA = regFile[i];
      if (bus.srcB == 4'(i)) arrB = regFile[i];
    end
  end

  assign rdA = bypassRead(bus.srcA, arrA, weE, bus.dstE, bus.valE,
                          weM, bus.dstM, bus.valM);
  assign rdB = bypassRead(bus.srcB, arrB, weE, bus.dstE, bus.valE,
                          weM, bus.dstM, bus.valM);

  // ---------------------------------------------------------------------------
  // Decode/execute pipeline register
  // ---------------------------------------------------------------------------
  pipeCtl_e pipeCtl;

  always_comb begin
    pipeCtl = PIPE_LOAD;
    if (reset)           pipeCtl = PIPE_RESET;
    else if (bus.stall)  pipeCtl = PIPE_HOLD;
    else if (bus.bubble) pipeCtl = PIPE_BUBBLE;
  end

  logic [DATA_W-1:0] valAQ;
  logic [DATA_W-1:0] valBQ;
  logic [3:0]        srcAQ;
  logic [3:0]        srcBQ;
  logic              validQ;

  // Reset and bubble load the same "empty slot" pattern.
  always_ff @(posedge clk) begin
    unique case (pipeCtl)
      PIPE_RESET, PIPE_BUBBLE: begin
        valAQ  <= '0;
        valBQ  <= '0;
        srcAQ  <= RNONE;
        srcBQ  <= RNONE;
        validQ <= 1'b0;
      end
      PIPE_HOLD: begin
        valAQ  <= valAQ;
        valBQ  <= valBQ;
        srcAQ  <= srcAQ;
        srcBQ  <= srcBQ;
        validQ <= validQ;
      end
      PIPE_LOAD: begin
        valAQ  <= rdA;
        valBQ  <= rdB;
        srcAQ  <= bus.srcA;
        srcBQ  <= bus.srcB;
        validQ <= bus.in_valid;
      end
      default: begin
        valAQ  <= valAQ;
        valBQ  <= valBQ;
        srcAQ  <= srcAQ;
        srcBQ  <= srcBQ;
        validQ <= validQ;
      end
    endcase
  end

  assign bus.valA      = valAQ;
  assign bus.valB      = valBQ;
  assign bus.srcA_q    = srcAQ;
  assign bus.srcB_q    = srcBQ;
  assign bus.out_valid = validQ;

endmodule

// File: tb/tb_decode_regfile_pipe.sv
// -----------------------------------------------------------------------------
// tb_decode_regfile_pipe
//
// Self-checking bench for decode_regfile_pipe (NUM_REGS=8, RSP_IDX=4,
// RSP_INIT=32'h100). Each vector drives one cycle of inputs and carries the
// outputs expected after the next rising edge; the expectation is queued when
// the vector is driven and popped once the edge has passed.
// -----------------------------------------------------------------------------
module tb_decode_regfile_pipe;

  localparam int         DATA_W = 32;
  localparam logic [3:0] NONE   = 4'hF;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  decode_regfile_pipe_if #(.DATA_W(DATA_W)) bus ();

  decode_regfile_pipe #(
    .DATA_W  (DATA_W),
    .NUM_REGS(8),
    .RSP_IDX (4),
    .RSP_INIT(32'h100),
    .RNONE   (NONE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic        inValid;
    logic [3:0]  dstE;
    logic [31:0] valE;
    logic [3:0]  dstM;
    logic [31:0] valM;
    logic        stall;
    logic        bubble;
    logic [31:0] expA;
    logic [31:0] expB;
    logic [3:0]  expSa;
    logic [3:0]  expSb;
    logic        expV;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] valA;
    logic [31:0] valB;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic        valid;
  } exp_t;

  int   testsRun    = 0;
  int   testsFailed = 0;
  exp_t scoreboard[$];
  vec_t vecs[$];

  function automatic vec_t mkVec(
    input string name, input logic rst,
    input logic [3:0] srcA, input logic [3:0] srcB, input logic inValid,
    input logic [3:0] dstE, input logic [31:0] valE,
    input logic [3:0] dstM, input logic [31:0] valM,
    input logic stall, input logic bubble,
    input logic [31:0] expA, input logic [31:0] expB,
    input logic [3:0] expSa, input logic [3:0] expSb, input logic expV
  );
    vec_t v;
    v.name = name;   v.rst = rst;
    v.srcA = srcA;   v.srcB = srcB;   v.inValid = inValid;
    v.dstE = dstE;   v.valE = valE;   v.dstM = dstM;   v.valM = valM;
    v.stall = stall; v.bubble = bubble;
    v.expA = expA;   v.expB = expB;
    v.expSa = expSa; v.expSb = expSb; v.expV = expV;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one vector, queue its expectation, then compare after the edge.
  task automatic runVec(input vec_t v);
    exp_t e;
    exp_t got;
    reset        = v.rst;
    bus.srcA     = v.srcA;
    bus.srcB     = v.srcB;
    bus.in_valid = v.inValid;
    bus.dstE     = v.dstE;
    bus.valE     = v.valE;
    bus.dstM     = v.dstM;
    bus.valM     = v.valM;
    bus.stall    = v.stall;
    bus.bubble   = v.bubble;
    e.name  = v.name;
    e.valA  = v.expA;
    e.valB  = v.expB;
    e.srcA  = v.expSa;
    e.srcB  = v.expSb;
    e.valid = v.expV;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    if (scoreboard.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", v.name);
    end else begin
      got = scoreboard.pop_front();
      check({got.name, ".valA"},      bus.valA,               got.valA);
      check({got.name, ".valB"},      bus.valB,               got.valB);
      check({got.name, ".srcA_q"},    {28'h0, bus.srcA_q},    {28'h0, got.srcA});
      check({got.name, ".srcB_q"},    {28'h0, bus.srcB_q},    {28'h0, got.srcB});
      check({got.name, ".out_valid"}, {31'h0, bus.out_valid}, {31'h0, got.valid});
    end
  endtask

  initial begin
    // name, rst, srcA, srcB, inV, dstE, valE, dstM, valM, stall, bubble,
    //   expA, expB, expSa, expSb, expV
    vecs.push_back(mkVec("reset_prio", 1, 4'd0, 4'd0, 1, 4'd1, 32'h55, NONE, 32'h0, 1, 1,
                         32'h0, 32'h0, NONE, NONE, 0));
    vecs.push_back(mkVec("rsp_init", 0, 4'd4, 4'd0, 1, NONE, 32'h0, NONE, 32'h0, 0, 0,
                         32'h100, 32'h0, 4'd4, 4'd0, 1));
    vecs.push_back(mkVec("reg1_after_rst", 0, 4'd1, NONE, 0, NONE, 32'h0, NONE, 32'h0, 0, 0,
                         32'h0, 32'h0, 4'd1, NONE, 0));
    vecs.push_back(mkVec("none_write", 0, NONE, 4'd0, 1, NONE, 32'hDEAD, NONE, 32'hBEEF, 0, 0,
                         32'h0, 32'h0, NONE, 4'd0, 1));
    vecs.push_back(mkVec("dual_wr_same", 0, NONE, NONE, 1, 4'd3, 32'h11, 4'd3, 32'h22, 0, 0,
                         32'h0, 32'h0, NONE, NONE, 1));
    vecs.push_back(mkVec("dual_rd_back", 0, 4'd3, 4'd4, 1, NONE, 32'h0, NONE, 32'h0, 0, 0,
                         32'h22, 32'h100, 4'd3, 4'd4, 1));
    vecs.push_back(mkVec("bypass_e", 0, 4'd2, 4'd2, 1, 4'd2, 32'hAB, NONE, 32'h0, 0, 0,
                         32'hAB, 32'hAB, 4'd2, 4'd2, 1));
    vecs.push_back(mkVec("array_after_byp", 0, 4'd2, 4'd3, 1, NONE, 32'h0, NONE, 32'h0, 0, 0,
                         32'hAB, 32'h22, 4'd2, 4'd3, 1));
    vecs.push_back(mkVec("bypass_m_wins", 0, 4'd5, 4'd5, 1, 4'd5, 32'hE5, 4'd5, 32'h55, 0, 0,
                         32'h55, 32'h55, 4'd5, 4'd5, 1));
    vecs.push_back(mkVec("bypass_split", 0, 4'd6, 4'd7, 1, 4'd6, 32'h66, 4'd7, 32'h77, 0, 0,
                         32'h66, 32'h77, 4'd6, 4'd7, 1));
    vecs.push_back(mkVec("illegal_e", 0, 4'd10, NONE, 1, 4'd10, 32'h7, NONE, 32'h0, 0, 0,
                         32'h0, 32'h0, 4'd10, NONE, 1));
    vecs.push_back(mkVec("illegal_m", 0, 4'd8, 4'd0, 1, NONE, 32'h0, 4'd8, 32'h99, 0, 0,
                         32'h0, 32'h0, 4'd8, 4'd0, 1));
    vecs.push_back(mkVec("scan_0_1", 0, 4'd0, 4'd1, 1, NONE, 32'h0, NONE, 32'h0, 0, 0,
                         32'h0, 32'h0, 4'd0, 4'd1, 1));
    vecs.push_back(mkVec("scan_2_3", 0, 4'd2, 4'd3, 1, NONE, 32'h0, NONE, 32'h0, 0, 0,
                         32'hAB, 32'h22, 4'd2, 4'd3, 1));
    vecs.push_back(mkVec("scan_4_5", 0, 4'd4, 4'd5, 1, NONE, 32'h0, NONE, 32'h0, 0, 0,
                         32'h100, 32'h55, 4'd4, 4'd5, 1));
    vecs.push_back(mkVec("scan_6_7", 0, 4'd6, 4'd7, 1, NONE, 32'h0, NONE, 32'h0, 0, 0,
                         32'h66, 32'h77, 4'd6, 4'd7, 1));

    bus.srcA = NONE; bus.srcB = NONE; bus.in_valid = 1'b0;
    bus.dstE = NONE; bus.valE = '0; bus.dstM = NONE; bus.valM = '0;
    bus.stall = 1'b0; bus.bubble = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) runVec(vecs[i]);

    // Stall holds a captured value across a later write; bubble then clears;
    // a plain load afterwards sees the write made during the stall.
    runVec(mkVec("cap_5", 0, 4'd1, NONE, 1, 4'd1, 32'h5, NONE, 32'h0, 0, 0,
                 32'h5, 32'h0, 4'd1, NONE, 1));
    runVec(mkVec("stall_wr9", 0, 4'd1, NONE, 1, 4'd1, 32'h9, NONE, 32'h0, 1, 0,
                 32'h5, 32'h0, 4'd1, NONE, 1));
    runVec(mkVec("stall_2", 0, 4'd2, 4'd3, 0, NONE, 32'h0, NONE, 32'h0, 1, 0,
                 32'h5, 32'h0, 4'd1, NONE, 1));
    runVec(mkVec("stall_3", 0, 4'd2, 4'd3, 0, NONE, 32'h0, NONE, 32'h0, 1, 0,
                 32'h5, 32'h0, 4'd1, NONE, 1));
    runVec(mkVec("bubble", 0, 4'd1, 4'd2, 1, NONE, 32'h0, NONE, 32'h0, 0, 1,
                 32'h0, 32'h0, NONE, NONE, 0));
    runVec(mkVec("load_9", 0, 4'd1, NONE, 1, NONE, 32'h0, NONE, 32'h0, 0, 0,
                 32'h9, 32'h0, 4'd1, NONE, 1));
    runVec(mkVec("stall_over_bub", 0, 4'd2, 4'd3, 0, NONE, 32'h0, NONE, 32'h0, 1, 1,
                 32'h9, 32'h0, 4'd1, NONE, 1));

    // Reset while stalled clears held outputs and the whole array.
    runVec(mkVec("rst_mid_stall", 1, 4'd2, 4'd3, 1, 4'd2, 32'h44, NONE, 32'h0, 1, 0,
                 32'h0, 32'h0, NONE, NONE, 0));
    runVec(mkVec("post_rst_4_1", 0, 4'd4, 4'd1, 1, NONE, 32'h0, NONE, 32'h0, 0, 0,
                 32'h100, 32'h0, 4'd4, 4'd1, 1));
    runVec(mkVec("post_rst_2_3", 0, 4'd2, 4'd3, 1, NONE, 32'h0, NONE, 32'h0, 0, 0,
                 32'h0, 32'h0, 4'd2, 4'd3, 1));

    if (scoreboard.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0",
               scoreboard.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
